// File: rtl/lcd_scanout.sv
// lcd_scanout: frame/line pacing and pixel scan-out for the LCD framebuffer.
// One rendered line is snapshotted per visible line and streamed through BGP.
module lcd_scanout #(
    parameter int LINE_DOTS     = 456,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154,
    parameter int LINE_WIDTH    = 160,
    parameter int FETCH_DELAY   = 2
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         enable,
    input  logic [VISIBLE_LINES-1:0][LINE_WIDTH-1:0][1:0] lcd,
    input  logic [7:0]                                   bgp,
    output logic                                         drawline,
    output logic                                         pix_valid,
    input  logic                                         pix_ready,
    output logic [1:0]                                   pix_data,
    output logic                                         pix_sol,
    output logic                                         pix_sof,
    output logic                                         pix_eol,
    output logic                                         vblank,
    output logic [7:0]                                   line_o,
    output logic                                         underrun
);

    localparam int DW  = $clog2(LINE_DOTS);
    localparam int LNW = $clog2(TOTAL_LINES);
    localparam int XW  = $clog2(LINE_WIDTH);

    localparam logic [DW-1:0]  DOT_LAST  = DW'(LINE_DOTS - 1);
    localparam logic [DW-1:0]  DOT_FETCH = DW'(FETCH_DELAY);
    localparam logic [LNW-1:0] LINE_LAST = LNW'(TOTAL_LINES - 1);
    localparam logic [LNW-1:0] VIS_LAST  = LNW'(VISIBLE_LINES - 1);
    localparam logic [LNW-1:0] VIS_NUM   = LNW'(VISIBLE_LINES);
    localparam logic [XW-1:0]  X_LAST    = XW'(LINE_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        STREAM,
        HBLANK,
        VBLANK
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [DW-1:0]                  r_dot;
    logic [LNW-1:0]                 r_line;
    logic [XW-1:0]                  r_x;
    logic                           r_underrun;
    logic [LINE_WIDTH-1:0][1:0]     r_buf;

    logic                           w_xfer;
    logic                           w_eol_xfer;
    logic                           w_dot_wrap;
    logic                           w_active;
    logic [1:0]                     w_code;
    logic [1:0]                     w_shade;
    state_t                         w_wrap_state;

    assign w_active   = (r_state != IDLE);
    assign w_dot_wrap = (r_dot == DOT_LAST);
    assign w_xfer     = (r_state == STREAM) && pix_ready;
    assign w_eol_xfer = w_xfer && (r_x == X_LAST);
    // Where a visible line goes once its dot counter wraps.
    assign w_wrap_state = (r_line < VIS_LAST) ? REQ : VBLANK;

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    w_next = REQ;
                REQ:     w_next = WAIT;
                WAIT:    if (r_dot == DOT_FETCH) w_next = STREAM;
                STREAM: begin
                    if (w_dot_wrap) w_next = w_wrap_state;
                    else if (w_eol_xfer) w_next = HBLANK;
                end
                HBLANK:  if (w_dot_wrap) w_next = w_wrap_state;
                VBLANK:  if (w_dot_wrap && r_line == LINE_LAST) w_next = REQ;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_dot      <= '0;
            r_line     <= '0;
            r_x        <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_state <= w_next;
            if (!enable || !w_active) begin
                r_dot  <= '0;
                r_line <= '0;
            end else if (w_dot_wrap) begin
                r_dot  <= '0;
                r_line <= (r_line == LINE_LAST) ? '0 : r_line + LNW'(1);
            end else begin
                r_dot <= r_dot + DW'(1);
            end
            // A transfer of the last pixel on the final dot still drains the line.
            if (!enable) begin
                r_underrun <= 1'b0;
            end else if (r_state == STREAM && w_dot_wrap && !w_eol_xfer) begin
                r_underrun <= 1'b1;
            end
            if (w_xfer) begin
                r_x <= w_eol_xfer ? '0 : r_x + XW'(1);
            end else if (r_state != STREAM) begin
                r_x <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == WAIT && r_dot == DOT_FETCH) begin
            r_buf <= lcd[r_line];
        end
    end

    assign w_code  = r_buf[r_x];
    assign w_shade = bgp[{w_code, 1'b0} +: 2];

    assign drawline  = (r_state == REQ);
    assign pix_valid = (r_state == STREAM);
    assign pix_data  = pix_valid ? w_shade : 2'b00;
    assign pix_sol   = pix_valid && (r_x == '0);
    assign pix_sof   = pix_valid && (r_x == '0) && (r_line == '0);
    assign pix_eol   = pix_valid && (r_x == X_LAST);
    assign vblank    = w_active && (r_line >= VIS_NUM);
    assign line_o    = 8'(r_line);
    assign underrun  = r_underrun;

endmodule
